// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package whack_pkg;

    // Sequencer states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DRAW = 3'd1,
        PICK = 3'd2,
        UP   = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } sched_state_t;

    localparam int SCORE_W   = 8;
    localparam int ROUND_W   = 5;
    localparam int LFSR_W    = 10;
    localparam int MAX_RETRY = 3;
    localparam int RETRY_W   = 2;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mole_timer.sv
// Loadable down-counter with a zero flag, shared by the lit and dark windows.
module mole_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mole_scheduler.sv
// Game sequencer: steps the external PRBS, picks a mole per round, lights it
// for a bounded window, judges presses and keeps score over a fixed game.
// start and btn are single-cycle pulses with no back-pressure: a pulse is
// acted on in the cycle it is sampled or it is dropped.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int NUM_MOLES  = 8,
    parameter int UP_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES = 25_000_000,
    parameter int ROUNDS     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    input  logic [9:0]           lfsr_seq,
    output logic                 shift_en,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic [7:0]           score,
    output logic [7:0]           miss,
    output logic [4:0]           round_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbgState
);

    localparam int MOLE_W  = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
    localparam int MAX_WIN = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;

    localparam logic [TIMER_W-1:0] UP_LOAD    = TIMER_W'(UP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);
    localparam logic [MOLE_W-1:0]  MOLE_MASK  = MOLE_W'(NUM_MOLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_CAP  = RETRY_W'(MAX_RETRY);

    sched_state_t state, stateNext;

    // mole holds the current round's mole; during PICK it is the previous one.
    logic [MOLE_W-1:0]  mole, moleNext, candidate;
    logic               hasPrev, hasPrevNext;
    logic [RETRY_W-1:0] retries, retryNext;
    logic [SCORE_W-1:0] scoreNext, missNext;
    logic [ROUND_W-1:0] roundNext;
    logic [NUM_MOLES-1:0] ledNext;

    logic               timerLoad, timerDec, timerZero;
    logic [TIMER_W-1:0] timerLoadVal;

    // Only the low bits of the PRBS word choose a mole.
    logic unusedLfsr;
    assign unusedLfsr = ^lfsr_seq[LFSR_W-1:MOLE_W];

    assign candidate = lfsr_seq[MOLE_W-1:0] & MOLE_MASK;
    assign dbgState  = state;

    mole_timer #(
        .WIDTH (TIMER_W)
    ) uTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timerLoad),
        .loadVal (timerLoadVal),
        .dec     (timerDec),
        .zero    (timerZero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, counter updates and timer control.
    always_comb begin
        stateNext    = state;
        moleNext     = mole;
        hasPrevNext  = hasPrev;
        retryNext    = retries;
        scoreNext    = score;
        missNext     = miss;
        roundNext    = round_cnt;
        timerLoad    = 1'b0;
        timerLoadVal = UP_LOAD;
        timerDec     = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    scoreNext   = '0;
                    missNext    = '0;
                    roundNext   = '0;
                    retryNext   = '0;
                    hasPrevNext = 1'b0;
                    stateNext   = DRAW;
                end
            end

            DRAW: stateNext = PICK;

            PICK: begin
                if (hasPrev && (candidate == mole) && (retries != RETRY_CAP)) begin
                    retryNext = retries + 1'b1;
                    stateNext = DRAW;
                end else begin
                    // Out of redraws: step past the previous mole instead.
                    if (retries == RETRY_CAP) begin
                        moleNext = (mole + 1'b1) & MOLE_MASK;
                    end else begin
                        moleNext = candidate;
                    end
                    hasPrevNext  = 1'b1;
                    retryNext    = '0;
                    timerLoad    = 1'b1;
                    timerLoadVal = UP_LOAD;
                    stateNext    = UP;
                end
            end

            UP: begin
                if (btn[mole]) begin
                    scoreNext    = satInc(score);
                    roundNext    = round_cnt + 1'b1;
                    timerLoad    = 1'b1;
                    timerLoadVal = GAP_LOAD;
                    stateNext    = GAP;
                end else begin
                    // A wrong press counts once but never shortens the window.
                    if (|btn) begin
                        missNext = satInc(miss);
                    end
                    if (timerZero) begin
                        roundNext    = round_cnt + 1'b1;
                        timerLoad    = 1'b1;
                        timerLoadVal = GAP_LOAD;
                        stateNext    = GAP;
                    end else begin
                        timerDec = 1'b1;
                    end
                end
            end

            GAP: begin
                if (timerZero) begin
                    stateNext = (round_cnt == LAST_ROUND) ? DONE : DRAW;
                end else begin
                    timerDec = 1'b1;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    // One-hot decode of the mole that will be lit next cycle.
    always_comb begin
        ledNext = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            ledNext[i] = (moleNext == MOLE_W'(i));
        end
    end

    // Datapath registers; outputs are decoded from the next state so they are
    // all flop outputs aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mole      <= '0;
            hasPrev   <= 1'b0;
            retries   <= '0;
            score     <= '0;
            miss      <= '0;
            round_cnt <= '0;
            shift_en  <= 1'b0;
            mole_led  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mole      <= moleNext;
            hasPrev   <= hasPrevNext;
            retries   <= retryNext;
            score     <= scoreNext;
            miss      <= missNext;
            round_cnt <= roundNext;
            shift_en  <= (stateNext == DRAW);
            mole_led  <= (stateNext == UP) ? ledNext : '0;
            busy      <= !((stateNext == IDLE) || (stateNext == DONE));
            done      <= (stateNext == DONE);
        end
    end

endmodule
